// File: rtl/cmlb_helpers_if.sv
// Bundle of the helper-library signals: incrementer operands, an LRU way set,
// and the CSR write bus feeding the register watcher.
interface cmlb_helpers_if #(
  parameter int AW = 6,
  parameter int LW = 3
);
  localparam int WAYS = 1 << LW;

  logic [AW-1:0]      add_a;
  logic               add_cin;
  logic [AW-1:0]      add_sum;
  logic               add_cout;

  logic [WAYS*LW-1:0] lru_cur;
  logic [WAYS*LW-1:0] lru_next;
  logic [LW-1:0]      hit_lru;
  logic               lru_init;
  logic               lru_en;

  logic [15:0]        msrss_addr;
  logic [64:0]        msrss_data;
  logic               msrss_en;
  logic [127:0]       watch_out;

  modport master (
    output add_a, add_cin, lru_cur, hit_lru, lru_init, lru_en,
           msrss_addr, msrss_data, msrss_en,
    input  add_sum, add_cout, lru_next, watch_out
  );

  modport slave (
    input  add_a, add_cin, lru_cur, hit_lru, lru_init, lru_en,
           msrss_addr, msrss_data, msrss_en,
    output add_sum, add_cout, lru_next, watch_out
  );
endinterface

// File: rtl/cmlb_helpers.sv
// Helper library: incrementer, single-way LRU age update, CSR shadow watcher.
// cmlb_helpers wraps one incrementer, a full LRU way set and one watcher.
module adder_inc #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out,
  input  logic             cin,
  output logic             cout
);
  assign {cout, out} = {1'b0, a} + (WIDTH+1)'(cin);
endmodule

module lru_single #(
  parameter int WIDTH = 3,
  parameter int ID    = 0
) (
  input  logic [WIDTH-1:0] lru,
  output logic [WIDTH-1:0] new_lru,
  input  logic [WIDTH-1:0] hit_lru,
  input  logic             init,
  input  logic             en
);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(ID);

  // Hit way becomes all-ones (MRU); ways younger than it age by one, so a
  // permutation across the set stays a permutation.
  always_comb begin
    new_lru = lru;
    if (init) begin
      new_lru = INIT_VAL;
    end else if (en) begin
      if (lru == hit_lru) begin
        new_lru = '1;
      end else if (lru > hit_lru) begin
        new_lru = lru - WIDTH'(1);
      end
    end
  end
endmodule

module msrss_watch #(
  parameter logic [15:0] ADDR = 16'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  msrss_addr,
  input  logic [64:0]  msrss_data,
  input  logic         msrss_en,
  output logic [127:0] out
);
  logic addr_hit;
  logic unused_ok;

  // Bit 15 of the address picks the thread, so it is excluded from the match.
  assign addr_hit  = msrss_en && (msrss_addr[14:0] == ADDR[14:0]);
  assign unused_ok = msrss_data[64];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_thread
      logic [63:0] data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (addr_hit && (int'(msrss_addr[15]) == gi)) begin
          data_reg <= msrss_data[63:0];
        end
      end

      assign out[gi*64 +: 64] = data_reg;
    end
  endgenerate
endmodule

module cmlb_helpers #(
  parameter int          AW         = 6,
  parameter int          LW         = 3,
  parameter logic [15:0] WATCH_ADDR = 16'h0
) (
  input  logic          clk,
  input  logic          rst,
  cmlb_helpers_if.slave bus
);
  localparam int WAYS = 1 << LW;

  adder_inc #(.WIDTH(AW)) u_adder (
    .a    (bus.add_a),
    .out  (bus.add_sum),
    .cin  (bus.add_cin),
    .cout (bus.add_cout)
  );

  // Way gi initialises to age gi, giving a valid permutation out of init.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      lru_single #(.WIDTH(LW), .ID(gi)) u_lru (
        .lru     (bus.lru_cur[gi*LW +: LW]),
        .new_lru (bus.lru_next[gi*LW +: LW]),
        .hit_lru (bus.hit_lru),
        .init    (bus.lru_init),
        .en      (bus.lru_en)
      );
    end
  endgenerate

  msrss_watch #(.ADDR(WATCH_ADDR)) u_watch (
    .clk        (clk),
    .rst        (rst),
    .msrss_addr (bus.msrss_addr),
    .msrss_data (bus.msrss_data),
    .msrss_en   (bus.msrss_en),
    .out        (bus.watch_out)
  );
endmodule

// File: tb/tb_cmlb_helpers.sv
// Scoreboard bench for cmlb_helpers: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cmlb_helpers;
  typedef struct {
    int           kind;  // 0 adder, 1 lru set, 2 watcher
    logic [127:0] val;
    string        name;
  } exp_t;

  typedef int vec8_t [8];

  typedef struct {
    logic         rst;
    logic         en;
    logic [15:0]  addr;
    logic [64:0]  data;
    logic [127:0] exp_after;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;

  cmlb_helpers_if #(.AW(6), .LW(3)) bus ();

  cmlb_helpers #(.AW(6), .LW(3), .WATCH_ADDR(16'h0123)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pack8(input vec8_t v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*3 +: 3] = 3'(v[i]);
    return r;
  endfunction

  task automatic push(input int kind, input logic [127:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: everything pushed during a cycle is checked on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [127:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        0:       act = {121'b0, bus.add_cout, bus.add_sum};
        1:       act = {104'b0, bus.lru_next};
        default: act = bus.watch_out;
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.val);
      end else begin
        $display("ok   %s: %h", e.name, act);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    wr_t wr [10];
    int  drained;

    rst            = 1'b1;
    bus.add_a      = '0;
    bus.add_cin    = 1'b0;
    bus.lru_cur    = '0;
    bus.hit_lru    = '0;
    bus.lru_init   = 1'b0;
    bus.lru_en     = 1'b0;
    bus.msrss_addr = '0;
    bus.msrss_data = '0;
    bus.msrss_en   = 1'b0;

    // Incrementer vectors: expected is {cout, out}.
    step(); bus.add_a = 6'd62; bus.add_cin = 1'b1; push(0, 128'd63, "add_62_inc");
    step(); bus.add_a = 6'd63; bus.add_cin = 1'b1; push(0, 128'd64, "add_63_wrap");
    step(); bus.add_a = 6'd5;  bus.add_cin = 1'b0; push(0, 128'd5,  "add_5_nocin");
    step(); bus.add_a = 6'd63; bus.add_cin = 1'b0; push(0, 128'd63, "add_63_nocin");
    step(); bus.add_a = 6'd31; bus.add_cin = 1'b1; push(0, 128'd32, "add_31_inc");

    // LRU set: way i sits at bits [3i+2:3i].
    step();
    bus.lru_init = 1'b1; bus.lru_en = 1'b1; bus.hit_lru = 3'd4;
    bus.lru_cur  = pack8('{6, 6, 6, 6, 6, 6, 6, 6});
    push(1, {104'b0, pack8('{0, 1, 2, 3, 4, 5, 6, 7})}, "lru_init_ids");
    step();
    bus.lru_init = 1'b0; bus.lru_en = 1'b1; bus.hit_lru = 3'd4;
    bus.lru_cur  = pack8('{4, 6, 2, 4, 6, 2, 4, 6});
    push(1, {104'b0, pack8('{7, 5, 2, 7, 5, 2, 7, 5})}, "lru_hit4_mixed");
    step();
    bus.lru_en = 1'b0;
    push(1, {104'b0, pack8('{4, 6, 2, 4, 6, 2, 4, 6})}, "lru_en0_hold");
    step();
    bus.lru_en = 1'b1; bus.hit_lru = 3'd3;
    bus.lru_cur = pack8('{0, 1, 2, 3, 4, 5, 6, 7});
    push(1, {104'b0, pack8('{0, 1, 2, 7, 3, 4, 5, 6})}, "lru_perm_hit3");
    step();
    bus.hit_lru = 3'd0;
    push(1, {104'b0, pack8('{7, 0, 1, 2, 3, 4, 5, 6})}, "lru_perm_miss0");
    step();
    bus.lru_en = 1'b0;

    // Watcher write sequence; exp_after is out just after that entry's edge.
    wr[0] = '{1'b1, 1'b0, 16'h0123, 65'h0, 128'h0};
    wr[1] = '{1'b0, 1'b1, 16'h0123, 65'h1_DEADBEEF_00000001,
              {64'h0, 64'hDEADBEEF00000001}};
    wr[2] = '{1'b0, 1'b1, 16'h8123, 65'h5, {64'h5, 64'hDEADBEEF00000001}};
    wr[3] = '{1'b0, 1'b1, 16'h0124, 65'hFF, {64'h5, 64'hDEADBEEF00000001}};
    wr[4] = '{1'b0, 1'b0, 16'h0123, 65'h77, {64'h5, 64'hDEADBEEF00000001}};
    wr[5] = '{1'b0, 1'b1, 16'h0123, 65'h11, {64'h5, 64'h11}};
    wr[6] = '{1'b0, 1'b1, 16'h0123, 65'h22, {64'h5, 64'h22}};
    wr[7] = '{1'b0, 1'b1, 16'h8123, 65'h33, {64'h33, 64'h22}};
    wr[8] = '{1'b1, 1'b1, 16'h0123, 65'h99, 128'h0};
    wr[9] = '{1'b0, 1'b1, 16'h8123, 65'h1_00000000_00000007, {64'h7, 64'h0}};

    for (int i = 0; i < 10; i++) begin
      step();
      rst            = wr[i].rst;
      bus.msrss_en   = wr[i].en;
      bus.msrss_addr = wr[i].addr;
      bus.msrss_data = wr[i].data;
      if (i > 0) push(2, wr[i-1].exp_after, $sformatf("watch_after_%0d", i-1));
    end
    step();
    rst          = 1'b0;
    bus.msrss_en = 1'b0;
    push(2, wr[9].exp_after, "watch_after_9");

    drained = 0;
    for (int c = 0; c < 10 && !drained; c++) begin
      step();
      if (sb_q.size() == 0) drained = 1;
    end
    if (!drained) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmlb_helpers.md
CMLB_HELPERS -- requirements
Module: cmlb_helpers (library of three leaf modules: adder_inc, lru_single, msrss_watch; each instantiable stand-alone)

Interface
REQ-001 adder_inc parameter: WIDTH, default 6, operand width in bits.
REQ-002 lru_single parameters: WIDTH, default 3, LRU field width; ID, default 0, way index used as init value.
REQ-003 msrss_watch parameter: ADDR, default 16'h0, 16-bit CSR address watched.
REQ-004 adder_inc ports (positional order): a  in  WIDTH  operand; out  out  WIDTH  sum; cin  in  1  increment/carry-in; cout  out  1  carry-out (may be left unconnected).
REQ-005 lru_single ports (positional order): lru  in  WIDTH  current way LRU; new_lru  out  WIDTH  updated LRU; hit_lru  in  WIDTH  LRU value of hit way; init  in  1  force init value; en  in  1  update enable.
REQ-006 msrss_watch ports (positional order): clk  in  1  clock; rst  in  1  reset; msrss_addr  in  16  CSR write address; msrss_data  in  65  CSR write data; msrss_en  in  1  CSR write strobe; out  out  128  per-thread register copies.
REQ-007 Reset rst, synchronous, active-high; clock clk (msrss_watch only; adder_inc and lru_single are purely combinational, no clk/rst).

Function
REQ-008 adder_inc: {cout,out} = a + cin, computed modulo 2^(WIDTH+1); zero latency.
REQ-009 adder_inc wrap: a = all-ones with cin=1 -> out=0, cout=1.
REQ-010 adder_inc: cin=0 -> out=a, cout=0.
REQ-011 lru_single priority 1: init=1 -> new_lru = ID[WIDTH-1:0], regardless of en/lru/hit_lru.
REQ-012 lru_single priority 2: init=0, en=0 -> new_lru = lru.
REQ-013 lru_single: init=0, en=1, lru == hit_lru -> new_lru = all-ones (most recently used).
REQ-014 lru_single: init=0, en=1, lru > hit_lru (unsigned) -> new_lru = lru - 1.
REQ-015 lru_single: init=0, en=1, lru < hit_lru -> new_lru = lru.
REQ-016 lru_single: across N=2^WIDTH ways holding a permutation of 0..N-1, update SHALL preserve the permutation (no duplicates); hit_lru=0 on miss rotates way at 0 to all-ones.
REQ-017 msrss_watch: out[63:0] = thread-0 register, out[127:64] = thread-1 register.
REQ-018 msrss_watch write match: msrss_en=1 and msrss_addr[14:0] == ADDR[14:0]; msrss_addr[15] selects thread (0 -> thread 0, 1 -> thread 1).
REQ-019 msrss_watch on match: selected thread register <= msrss_data[63:0] at next rising clk; msrss_data[64] ignored; other thread unchanged.
REQ-020 msrss_watch: out is direct register output (1-cycle write-to-read latency); no match -> registers hold.
REQ-021 msrss_watch: back-to-back writes on consecutive cycles each take effect; last write wins per thread.

Reset
REQ-022 msrss_watch: rst=1 at rising clk -> both thread registers = 0 (out = 128'h0); rst has priority over a simultaneous matching write.
REQ-023 adder_inc and lru_single hold no state; outputs valid whenever inputs are.

Verification
REQ-024 adder_inc WIDTH=6: a=6'd62,cin=1 -> out=63,cout=0; a=6'd63,cin=1 -> out=0,cout=1; a=5,cin=0 -> out=5.
REQ-025 lru_single WIDTH=3: init=1,ID=5 -> 5; en=1,lru=4,hit=4 -> 7; lru=6,hit=4 -> 5; lru=2,hit=4 -> 2; en=0,lru=6,hit=4 -> 6.
REQ-026 lru_single 8-way set with lru=0..7, hit_lru=3 applied to all -> results {0,1,2,7,3,4,5,6}, still a permutation.
REQ-027 msrss_watch ADDR=16'h0123: rst -> out=0; write addr 16'h0123 data 65'h1_DEADBEEF_00000001 -> next cycle out[63:0]=64'hDEADBEEF00000001, out[127:64]=0.
REQ-028 msrss_watch: write addr 16'h8123 data 5 -> out[127:64]=5, thread 0 unchanged; write addr 16'h0124 -> no change; msrss_en=0 with matching addr -> no change.
REQ-029 msrss_watch: matching write concurrent with rst=1 -> out=0 after edge.
